// File: rtl/cpu_pkg.sv
// Shared CPU constants and PC sequencer FSM state encoding.
// Consumed by pc_sequencer and ret_depth_ctr.
package cpu_pkg;

    localparam int CPU_PC_W  = 10;
    localparam int CPU_DEPTH = 32;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        RET_WAIT = 2'd1,
        RET_LOAD = 2'd2
    } seq_state_t;

endpackage

// File: rtl/ret_depth_ctr.sv
// Return-stack occupancy counter (0..DEPTH) with full/empty flags.
// Only instantiated when STACK_GUARD_EN is defined.
module ret_depth_ctr
    import cpu_pkg::*;
#(
    parameter int DEPTH = CPU_DEPTH
) (
    input  logic clk,
    input  logic reset,
    input  logic i_inc,
    input  logic i_dec,
    output logic o_full,
    output logic o_empty
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (i_inc && !i_dec) begin
            r_cnt <= r_cnt + CW'(1);
        end else if (i_dec && !i_inc) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    assign o_full  = (r_cnt == CW'(DEPTH));
    assign o_empty = (r_cnt == '0);

endmodule

// File: rtl/pc_sequencer.sv
// Program counter sequencer with call/return strobes to an external stack.
// Define STACK_GUARD_EN to add depth tracking and the sticky err flag.
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter int              PC_W     = CPU_PC_W,
    parameter int              DEPTH    = CPU_DEPTH,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic            jump,
    input  logic            call,
    input  logic            ret,
    input  logic [PC_W-1:0] target,
    input  logic [PC_W-1:0] stackOut,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] stackIn,
    output logic            push,
    output logic            pop,
    output logic            busy,
    output logic            err
);

    seq_state_t      r_state;
    seq_state_t      w_state_nx;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_nx;
    logic [PC_W-1:0] r_stack_in;
    logic [PC_W-1:0] w_stack_in_nx;
    logic            r_push;
    logic            w_push_nx;
    logic            r_pop;
    logic            w_pop_nx;
    logic            r_busy;
    logic            w_busy_nx;
    logic            w_go;
    logic            w_full;
    logic            w_empty;

    assign w_go = en && (r_state == RUN);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc       <= RESET_PC;
            r_stack_in <= '0;
            r_push     <= 1'b0;
            r_pop      <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_pc       <= w_pc_nx;
            r_stack_in <= w_stack_in_nx;
            r_push     <= w_push_nx;
            r_pop      <= w_pop_nx;
            r_busy     <= w_busy_nx;
        end
    end

    // Strobes default low so push/pop last exactly one cycle.
    always_comb begin
        w_state_nx    = r_state;
        w_pc_nx       = r_pc;
        w_stack_in_nx = r_stack_in;
        w_push_nx     = 1'b0;
        w_pop_nx      = 1'b0;
        w_busy_nx     = r_busy;
        unique case (r_state)
            RUN: begin
                if (w_go) begin
                    if (ret) begin
                        if (!w_empty) begin
                            w_state_nx = RET_WAIT;
                            w_pop_nx   = 1'b1;
                            w_busy_nx  = 1'b1;
                        end
                    end else if (call) begin
                        if (!w_full) begin
                            w_pc_nx       = target;
                            w_stack_in_nx = r_pc + PC_W'(1);
                            w_push_nx     = 1'b1;
                        end
                    end else if (jump) begin
                        w_pc_nx = target;
                    end else begin
                        w_pc_nx = r_pc + PC_W'(1);
                    end
                end
            end
            RET_WAIT: begin
                w_state_nx = RET_LOAD;
            end
            RET_LOAD: begin
                w_pc_nx    = stackOut;
                w_busy_nx  = 1'b0;
                w_state_nx = RUN;
            end
            default: begin
                w_state_nx = RUN;
            end
        endcase
    end

`ifdef STACK_GUARD_EN
    logic w_do_call;
    logic w_do_ret;
    logic w_blocked;
    logic r_err;

    assign w_do_ret  = w_go && ret && !w_empty;
    assign w_do_call = w_go && !ret && call && !w_full;
    assign w_blocked = w_go && ((ret && w_empty) ||
                                (!ret && call && w_full));

    ret_depth_ctr #(
        .DEPTH (DEPTH)
    ) u_depth (
        .clk     (clk),
        .reset   (reset),
        .i_inc   (w_do_call),
        .i_dec   (w_do_ret),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err <= 1'b0;
        end else if (w_blocked) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign w_full  = 1'b0;
    assign w_empty = 1'b0;
    assign err     = 1'b0;
`endif

    assign pc      = r_pc;
    assign stackIn = r_stack_in;
    assign push    = r_push;
    assign pop     = r_pop;
    assign busy    = r_busy;

endmodule
